// File: rtl/mm_pkg.sv
// mm_pkg: shared widths and state encoding for the Karatsuba multiplier and limb combiner.
package mm_pkg;
    localparam int MM_A_W = 256;
    localparam int MM_B_W = 128;
    localparam int MM_PW = MM_A_W + MM_B_W;
    localparam int MM_LW = 128;
    localparam int MM_NLIMB = 2;
    localparam int MM_OW = MM_PW + MM_LW * (MM_NLIMB - 1);
    localparam int MM_TIMEOUT = 16;
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;
endpackage

// File: rtl/limb_shift_add.sv
// limb_shift_add: acc + (p << LW*idx), p zero-extended to OW and the sum truncated to OW bits.
module limb_shift_add #(
    parameter int PW = 384,
    parameter int LW = 128,
    parameter int OW = 512,
    parameter int IW = 1
) (
    input  logic [OW-1:0] acc,
    input  logic [PW-1:0] p,
    input  logic [IW-1:0] idx,
    output logic [OW-1:0] sum
);
    assign sum = acc + (OW'(p) << (LW * int'(idx)));
endmodule

// File: rtl/limb_product_combiner.sv
// limb_product_combiner: accumulates LSB-first limb partial products into one registered full product.
// Define COMBINER_TIMEOUT_EN to add an idle watchdog that abandons a stalled operand.
module limb_product_combiner
    import mm_pkg::*;
#(
    parameter int PW = MM_PW,
    parameter int LW = MM_LW,
    parameter int NLIMB = MM_NLIMB,
`ifdef COMBINER_TIMEOUT_EN
    parameter int TIMEOUT = MM_TIMEOUT,
`endif
    localparam int OW = PW + LW * (NLIMB - 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [PW-1:0] P_in,
    input  logic          in_valid,
    input  logic          in_first,
    output logic [OW-1:0] R,
    output logic          out_valid,
    output logic          err
);
    localparam int IW = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NLIMB - 1);

    state_t state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [OW-1:0] acc, acc_n, r_n, sum;
    logic ov_n, err_n;

    limb_shift_add #(.PW(PW), .LW(LW), .OW(OW), .IW(IW)) u_add (
        .acc(acc),
        .p(P_in),
        .idx(idx),
        .sum(sum)
    );

`ifdef COMBINER_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd, wd_n, wd_inc;
    assign wd_inc = wd + 1'b1;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) wd <= '0;
        else wd <= wd_n;
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx <= '0;
            acc <= '0;
            R <= '0;
            out_valid <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            acc <= acc_n;
            R <= r_n;
            out_valid <= ov_n;
            err <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n = idx;
        acc_n = acc;
        r_n = R;
        ov_n = 1'b0;
        err_n = 1'b0;
`ifdef COMBINER_TIMEOUT_EN
        wd_n = '0;
`endif
        if (in_valid) begin
            if (in_first) begin
                // an in_first beat always restarts, abandoning any partial operand
                err_n = (state == ACCUM);
                if (NLIMB == 1) begin
                    r_n = OW'(P_in);
                    ov_n = 1'b1;
                    state_n = IDLE;
                    idx_n = '0;
                    acc_n = '0;
                end else begin
                    acc_n = OW'(P_in);
                    idx_n = IW'(1);
                    state_n = ACCUM;
                end
            end else if (state == IDLE) begin
                err_n = 1'b1;
            end else if (idx == LAST) begin
                r_n = sum;
                ov_n = 1'b1;
                acc_n = '0;
                idx_n = '0;
                state_n = IDLE;
            end else begin
                acc_n = sum;
                idx_n = idx + 1'b1;
            end
        end
`ifdef COMBINER_TIMEOUT_EN
        else if (state == ACCUM) begin
            wd_n = wd_inc;
            if (wd_inc == WDW'(TIMEOUT)) begin
                wd_n = '0;
                state_n = IDLE;
                acc_n = '0;
                idx_n = '0;
                err_n = 1'b1;
            end
        end
`endif
    end
endmodule

// File: tb/tb_limb_product_combiner.sv
// tb_limb_product_combiner: directed vectors with hand-computed products for limb_product_combiner.
module tb_limb_product_combiner;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [383:0] P_in = '0;
    logic in_valid = 1'b0;
    logic in_first = 1'b0;
    logic [511:0] R;
    logic out_valid, err;
    int tests = 0;
    int failed = 0;

    localparam logic [511:0] ONE_128 = {384'h0, 128'h0} | (512'h1 << 128);
    localparam logic [511:0] WRAP = {128'h0, 128'hffffffffffffffffffffffffffffffff,
                                     128'hfffffffffffffffffffffffffffffffe,
                                     128'hffffffffffffffffffffffffffffffff};

    limb_product_combiner dut (
        .clock(clock),
        .reset(reset),
        .P_in(P_in),
        .in_valid(in_valid),
        .in_first(in_first),
        .R(R),
        .out_valid(out_valid),
        .err(err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic f, input logic [383:0] p);
        in_valid = v;
        in_first = f;
        P_in = p;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("reset_R", R, 512'h0);
        chk("reset_ov", out_valid, 0);
        chk("reset_err", err, 0);
        reset = 1'b0;

        step(1, 1, 384'd1);
        chk("basic_p0_ov", out_valid, 0);
        step(1, 0, 384'd1);
        chk("basic_R", R, ONE_128 + 512'd1);
        chk("basic_ov", out_valid, 1);
        chk("basic_err", err, 0);
        step(0, 0, 384'd0);
        chk("basic_ov_pulse", out_valid, 0);

        step(1, 1, {384{1'b1}});
        step(1, 0, {384{1'b1}});
        chk("wrap_R", R, WRAP);
        chk("wrap_ov", out_valid, 1);

        step(1, 1, 384'd5);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 384'd0);
            chk("gap_ov", out_valid, 0);
        end
        step(1, 0, 384'd3);
        chk("gap_R", R, (512'd3 << 128) + 512'd5);
        chk("gap_ov_end", out_valid, 1);
        step(1, 1, 384'd7);
        chk("b2b_first_ov", out_valid, 0);
        chk("b2b_first_err", err, 0);
        chk("b2b_hold_R", R, (512'd3 << 128) + 512'd5);
        step(1, 0, 384'd0);
        chk("b2b_R", R, 512'd7);
        chk("b2b_ov", out_valid, 1);

        step(1, 0, 384'd42);
        chk("idle_err", err, 1);
        chk("idle_ov", out_valid, 0);
        chk("idle_R", R, 512'd7);
        step(0, 0, 384'd0);
        chk("idle_err_pulse", err, 0);

        step(1, 1, 384'd9);
        step(1, 1, 384'd2);
        chk("abort_err", err, 1);
        chk("abort_ov", out_valid, 0);
        step(1, 0, 384'd1);
        chk("abort_R", R, ONE_128 + 512'd2);
        chk("abort_ov_end", out_valid, 1);
        chk("abort_err_end", err, 0);

        step(1, 1, 384'd3);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_R", R, 512'h0);
        chk("async_rst_ov", out_valid, 0);
        @(negedge clock);
        reset = 1'b0;
        step(1, 0, 384'd8);
        chk("post_rst_nonfirst_err", err, 1);
        chk("post_rst_nonfirst_ov", out_valid, 0);
        step(1, 1, 384'd4);
        step(1, 0, 384'd1);
        chk("post_rst_R", R, ONE_128 + 512'd4);
        chk("post_rst_ov", out_valid, 1);

        step(1, 1, 384'd1);
`ifdef COMBINER_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 384'd0);
            chk("wd_quiet_err", err, 0);
        end
        step(0, 0, 384'd0);
        chk("wd_err", err, 1);
        step(1, 0, 384'd5);
        chk("wd_idle_err", err, 1);
        chk("wd_idle_ov", out_valid, 0);
        chk("wd_R_hold", R, ONE_128 + 512'd4);
`else
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 384'd0);
            chk("long_gap_err", err, 0);
        end
        step(1, 0, 384'd5);
        chk("long_gap_R", R, (512'd5 << 128) + 512'd1);
        chk("long_gap_ov", out_valid, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/limb_product_combiner.md
Name: limb_product_combiner

Overview:
Downstream stage of the constant-operand 256x128 Karatsuba multiplier. Consumes its stream of 384-bit partial products, one per 128-bit limb of the variable operand, least-significant limb first. Accumulates them with the correct 128-bit limb shifts into the full-width product, e.g. 256x256 -> 512 bits. Feeds the modular reduction stage with one registered full product per operand.

Parameters:
PW, 384, partial-product width (width of multiplier output P)
LW, 128, limb width; beat i is weighted by 2^(LW*i)
NLIMB, 2, partial products per full product (>=1)
OW, PW+LW*(NLIMB-1), full-product width (derived localparam, 512 by default)
TIMEOUT, 16, idle-cycle limit for the optional watchdog

Ports:
clock  in  1  single clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
P_in  in  PW  partial product from the Karatsuba stage
in_valid  in  1  P_in valid this cycle; no backpressure, every valid beat must be taken
in_first  in  1  qualifies a valid beat as limb 0 of a new operand
R  out  OW  full product; holds its last value between results
out_valid  out  1  one-cycle pulse, R valid
err  out  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset (async assert): state=IDLE, idx=0, acc=0, R=0, out_valid=0, err=0. Deassertion is used synchronously.
- Registers: acc[OW-1:0], idx (clog2(NLIMB) bits, min 1), R, out_valid, err.
- State IDLE:
  - in_valid & in_first: acc <= zero-extended P_in, idx <= 1, go to ACCUM.
  - If NLIMB==1, instead R <= P_in, out_valid <= 1, stay in IDLE.
  - in_valid & !in_first: beat dropped, err <= 1.
- State ACCUM:
  - in_valid low: hold everything; gaps of any length are allowed.
  - in_valid & !in_first: sum = acc + (P_in << LW*idx), truncated mod 2^OW.
    - If idx==NLIMB-1: R <= sum, out_valid <= 1, acc <= 0, idx <= 0, go to IDLE.
    - Otherwise acc <= sum, idx <= idx+1.
  - in_valid & in_first: the partial operand is abandoned. err <= 1 and the beat restarts accumulation exactly as from IDLE.
- Latency: out_valid rises on the clock edge that samples the last limb. It is visible in the following cycle, one-cycle registered.
- Throughput: one beat per cycle. Back-to-back operands are fully supported: a last beat followed immediately by in_first loses no cycle.
- Arithmetic:
  - Unsigned throughout.
  - Shifted terms are zero-extended to OW before the add.
  - Overflow beyond OW bits wraps silently; it is impossible when inputs are true limb products.
- out_valid and err are cleared every cycle unless set as above. Both may assert in the same cycle only when NLIMB==1 and an in_first beat aborts; this case cannot arise in practice.
- Reset mid-operation: the partial accumulation is discarded, no out_valid, and the next operand must start with in_first.

Optional Feature:
COMBINER_TIMEOUT_EN:
- Defined: a watchdog counter counts consecutive ACCUM cycles with in_valid low. It resets on any valid beat or on leaving ACCUM. When the count reaches TIMEOUT, state goes to IDLE, acc=0, idx=0, and err pulses for one cycle.
- Undefined: no counter is present and ACCUM waits indefinitely.

Decomposition:
- Shared package mm_pkg:
  - localparams PW/LW/NLIMB/OW defaults.
  - State enum encoding (IDLE=0, ACCUM=1).
  - The multiplier's operand widths, so the multiplier and combiner agree.
- One natural sub-module, limb_shift_add: combinational acc + (P_in << LW*idx) with zero-extension and OW truncation. It is reused later by the reduction stage.

Test Plan:
- Basic: beats P0=1 (first), P1=1 -> next cycle R=2^128+1 (hex 0x...01_0000...0001), out_valid=1 for exactly one cycle, err=0.
- Wrap: P0=P1=2^384-1 -> R = 2^384-2^128-1 mod 2^512, i.e. bits 383..129=1, bit128=0, bits127..0=1, top 128 bits 0.
- Gaps and back-to-back:
  - P0=5, three idle cycles, P1=3 -> R=3*2^128+5.
  - Immediately after, P0=7 (first), P1=0 -> R=7 on the next pulse.
  - No dropped beats.
- Protocol errors:
  - non-first beat in IDLE -> err pulse, R unchanged, no out_valid.
  - P0=9 then in_first with P0=2, then P1=1 -> err pulse, R=2^128+2.
- Reset: assert reset asynchronously between P0 and P1 -> R=0, out_valid=0 immediately. A following first+last pair with 4 and 1 gives R=2^128+4.
- Timeout (macro defined, TIMEOUT=16): P0=1 then 16 idle cycles -> err pulse, state IDLE. A later non-first beat -> another err, no out_valid.
